// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative mul/div sequencer for EX, owns HI/LO and MTHI/MTLO.
// Define MULDIV_FAST_MUL_EN to compute MUL with a single-cycle multiplier.
module muldiv_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [4:0]  func,
    input  logic        sign,
    input  logic [31:0] source_a,
    input  logic [31:0] source_b,
    input  logic        flush,
    input  logic        hi_write,
    input  logic        lo_write,
    input  logic [31:0] hi_write_data,
    input  logic [31:0] lo_write_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam logic [4:0] FUNC_DIV = 5'd2;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic        is_div;
    logic        neg_q;
    logic        neg_r;
    logic [31:0] op_x;
    logic [63:0] acc;

    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic        accept;
    logic        commit;
    logic        start_div;
    logic [32:0] mul_sum;
    logic [32:0] rem_sh;
    logic        rem_ge;
    logic [31:0] rem_sub;
    logic [63:0] step;
    logic [63:0] raw_prod;
    logic [63:0] res;

    assign abs_a     = (sign & source_a[31]) ? -source_a : source_a;
    assign abs_b     = (sign & source_b[31]) ? -source_b : source_b;
    assign accept    = (state == IDLE) & start & ~flush;
    assign commit    = (state == FIX) & ~flush;
    assign start_div = (func == FUNC_DIV);

    // acc is {partial product, multiplier} for MUL, {remainder, quotient} for DIV
    assign mul_sum = {1'b0, acc[63:32]} + {1'b0, op_x};
    assign rem_sh  = acc[63:31];
    assign rem_ge  = rem_sh >= {1'b0, op_x};
    assign rem_sub = rem_sh[31:0] - op_x;

    always_comb begin
        step = '0;
        if (is_div) begin
            step = rem_ge ? {rem_sub, acc[30:0], 1'b1} : {acc[62:0], 1'b0};
        end else begin
            step = acc[0] ? {mul_sum, acc[31:1]} : {1'b0, acc[63:1]};
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    assign raw_prod = {32'b0, op_x} * {32'b0, acc[31:0]};
`else
    assign raw_prod = acc;
`endif

    always_comb begin
        res = '0;
        if (is_div) begin
            res[31:0]  = neg_q ? -acc[31:0] : acc[31:0];
            res[63:32] = neg_r ? -acc[63:32] : acc[63:32];
        end else begin
            res = neg_q ? -raw_prod : raw_prod;
        end
    end

    assign busy = resetn & (accept | (state == CALC));
    assign done = commit;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            op_x   <= '0;
            acc    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        is_div <= start_div;
                        neg_q  <= sign & (source_a[31] ^ source_b[31]);
                        neg_r  <= sign & source_a[31];
                        op_x   <= start_div ? abs_b : abs_a;
                        acc    <= {32'b0, start_div ? abs_a : abs_b};
                        cnt    <= '0;
`ifdef MULDIV_FAST_MUL_EN
                        state  <= start_div ? CALC : FIX;
`else
                        state  <= CALC;
`endif
                    end
                end
                CALC: begin
                    acc <= step;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= FIX;
                end
                FIX:     state <= IDLE;
                default: state <= IDLE;
            endcase
            if (flush) state <= IDLE;
        end
    end

    // the FIX commit wins over an MTHI/MTLO on the same edge
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi <= '0;
            lo <= '0;
        end else if (commit) begin
            hi <= res[63:32];
            lo <= res[31:0];
        end else begin
            if (hi_write) hi <= hi_write_data;
            if (lo_write) lo <= lo_write_data;
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed and randomized checks of muldiv_ctrl.
// Expected HI/LO come from plain 64-bit arithmetic on the operands.
module tb_muldiv_ctrl;
    localparam logic [4:0] FUNC_MUL = 5'd1;
    localparam logic [4:0] FUNC_DIV = 5'd2;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    logic        clk;
    logic        resetn;
    logic        start;
    logic [4:0]  func;
    logic        sign;
    logic [31:0] source_a;
    logic [31:0] source_b;
    logic        flush;
    logic        hi_write;
    logic        lo_write;
    logic [31:0] hi_write_data;
    logic [31:0] lo_write_data;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests = 0;
    int fails = 0;

    muldiv_ctrl dut (
        .clk           (clk),
        .resetn        (resetn),
        .start         (start),
        .func          (func),
        .sign          (sign),
        .source_a      (source_a),
        .source_b      (source_b),
        .flush         (flush),
        .hi_write      (hi_write),
        .lo_write      (lo_write),
        .hi_write_data (hi_write_data),
        .lo_write_data (lo_write_data),
        .busy          (busy),
        .done          (done),
        .hi            (hi),
        .lo            (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input bit div, input bit sgn,
                                          input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        sa = sgn ? longint'($signed(a)) : longint'({32'b0, a});
        sb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
        if (!div) return sa * sb;
        if (b == 32'h0) return {a, ((sgn && a[31]) ? 32'h1 : 32'hFFFF_FFFF)};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic mt(input logic [31:0] h, input logic [31:0] l);
        @(posedge clk); #1;
        hi_write = 1'b1; hi_write_data = h;
        lo_write = 1'b1; lo_write_data = l;
        @(posedge clk); #1;
        hi_write = 1'b0;
        lo_write = 1'b0;
    endtask

    task automatic run_op(input logic [4:0] f, input bit s, input logic [31:0] a,
                          input logic [31:0] b, input bit chain, input string tag);
        logic [63:0] exp;
        int nb;
        int early;
        int exp_busy;
        exp = model(f == FUNC_DIV, s, a, b);
        exp_busy = (f == FUNC_DIV) ? 33 : MUL_LAT;
        nb = 0;
        early = 0;
        if (start) nb = 1;
        else begin
            @(posedge clk); #1;
        end
        start = 1'b1; func = f; sign = s; source_a = a; source_b = b;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
            nb++;
            if (done) early++;
        end
        chk({tag, "_busy"}, 64'(nb), 64'(exp_busy));
        chk({tag, "_done"}, {63'b0, done}, 64'd1);
        chk({tag, "_early"}, 64'(early), 64'd0);
        @(posedge clk); #1;
        start = chain;
        @(negedge clk);
        chk({tag, "_hilo"}, {hi, lo}, exp);
        if (chain) chk({tag, "_b2b"}, {63'b0, busy}, 64'd1);
        else chk({tag, "_pulse"}, {63'b0, done}, 64'd0);
    endtask

    initial begin
        int nd;
        logic [4:0] f;
        bit s;
        logic [31:0] a;
        logic [31:0] b;
        clk = 0; resetn = 0; start = 0; func = '0; sign = 0;
        source_a = '0; source_b = '0; flush = 0;
        hi_write = 0; lo_write = 0; hi_write_data = '0; lo_write_data = '0;

        #12;
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_done", {63'b0, done}, 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        @(posedge clk); #1;
        resetn = 1;

        run_op(FUNC_MUL, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mul_max");
        run_op(FUNC_DIV, 1, 32'hFFFF_FFF9, 32'h0000_0002, 0, "div_m7_2");
        run_op(FUNC_DIV, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
        run_op(FUNC_DIV, 0, 32'h0000_0005, 32'h0000_0000, 0, "div_u5_0");
        run_op(FUNC_DIV, 1, 32'hFFFF_FFFB, 32'h0000_0000, 0, "div_s5_0");
        run_op(FUNC_MUL, 1, 32'h8000_0000, 32'h8000_0000, 1, "b2b_a");
        run_op(FUNC_DIV, 0, 32'h1234_5678, 32'h0000_0100, 0, "b2b_b");

        // flush in the middle of CALC
        mt(32'hAAAA_0000, 32'h0000_5555);
        @(posedge clk); #1;
        start = 1; func = FUNC_DIV; sign = 0; source_a = 100; source_b = 7;
        repeat (10) begin @(posedge clk); #1; end
        flush = 1;
        @(posedge clk); #1;
        flush = 0; start = 0;
        @(negedge clk);
        chk("flush_idle", {63'b0, busy}, 64'd0);
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("flush_nodone", 64'(nd), 64'd0);
        chk("flush_hilo", {hi, lo}, 64'hAAAA_0000_0000_5555);

        // flush in the FIX cycle
        @(posedge clk); #1;
        start = 1; func = FUNC_DIV; sign = 0; source_a = 100; source_b = 7;
        repeat (33) begin @(posedge clk); #1; end
        flush = 1;
        @(negedge clk);
        chk("fixflush_done", {63'b0, done}, 64'd0);
        @(posedge clk); #1;
        flush = 0; start = 0;
        @(negedge clk);
        chk("fixflush_hilo", {hi, lo}, 64'hAAAA_0000_0000_5555);

        // -3*4, MTLO in FIX is dropped, MTHI right after commit lands
        @(posedge clk); #1;
        start = 1; func = FUNC_MUL; sign = 1;
        source_a = 32'hFFFF_FFFD; source_b = 32'h0000_0004;
        repeat (MUL_LAT) begin @(posedge clk); #1; end
        lo_write = 1; lo_write_data = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("mt_fixdone", {63'b0, done}, 64'd1);
        @(posedge clk); #1;
        lo_write = 0; start = 0;
        hi_write = 1; hi_write_data = 32'h0000_1234;
        @(negedge clk);
        chk("mt_commit", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF4);
        @(posedge clk); #1;
        hi_write = 0;
        @(negedge clk);
        chk("mt_mthi", {hi, lo}, 64'h0000_1234_FFFF_FFF4);

        for (int k = 0; k < 16; k++) begin
            f = ($urandom_range(0, 1) == 0) ? FUNC_MUL : FUNC_DIV;
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 5)) : $urandom;
            run_op(f, s, a, b, 0, "rnd");
        end

        // asynchronous reset in the middle of CALC
        mt(32'h1234_5678, 32'h9ABC_DEF0);
        @(posedge clk); #1;
        start = 1; func = FUNC_DIV; sign = 0; source_a = 1000; source_b = 3;
        repeat (10) @(posedge clk);
        #2;
        resetn = 0;
        #1;
        chk("arst_busy", {63'b0, busy}, 64'd0);
        chk("arst_done", {63'b0, done}, 64'd0);
        chk("arst_hilo", {hi, lo}, 64'd0);
        start = 0;
        @(posedge clk); #1;
        resetn = 1;
        run_op(FUNC_MUL, 0, 32'd6, 32'd7, 0, "rst_mul");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multi-cycle multiply/divide sequencer for the EX stage. It accepts the operation that the single-cycle ALU flags as `FUNC_MUL`/`FUNC_DIV` (with signedness) and runs an iterative magnitude engine. It stalls the pipeline while computing and owns the architectural HI/LO registers, including the MTHI/MTLO write paths. Results commit to HI/LO before the issuing instruction leaves EX, so the next instruction's MFHI/MFLO sees them.

## Interface
- No parameters; data width fixed at 32 (`W_DATA`), func at 5 (`W_FUNC`).
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- start  in  1  EX holds a mul/div op; `mulalu_func` is nonzero
- func  in  5  `FUNC_MUL` or `FUNC_DIV`; sampled only on acceptance
- sign  in  1  1 = signed (MULT/DIV), 0 = unsigned
- source_a  in  32  multiplicand / dividend
- source_b  in  32  multiplier / divisor
- flush  in  1  cancel any operation in flight (exception/eret)
- hi_write, lo_write  in  1  MTHI/MTLO strobes
- hi_write_data, lo_write_data  in  32  MTHI/MTLO data
- busy  out  1  stall request to EX and earlier stages
- done  out  1  one-cycle pulse on commit
- hi, lo  out  32  architectural HI/LO, registered

## Operation
- States: IDLE, CALC, FIX.
- **Acceptance:** `start` is accepted only in IDLE with `flush` = 0.
  - On acceptance: latch `func`, `sign`, |a|, |b|, and the result signs.
  - Magnitudes use two's-complement absolute value when `sign` = 1; `0x80000000` becomes magnitude `0x80000000`.
  - Clear the iteration counter, then go to CALC.
- **CALC (MUL):** radix-2 shift-add on 64-bit accumulator, one bit per cycle, 32 cycles.
- **CALC (DIV):** radix-2 restoring division, 32 cycles, on a 33-bit partial remainder.
- **CALC exit:** counter 5 bits; leave CALC when counter = 31, then go to FIX.
- **FIX:** apply sign correction and write HI/LO at the end of the cycle, pulse `done`, then return to IDLE.
  - MUL: {HI,LO} = product, negated if the operand signs differ.
  - DIV: LO = quotient, negated if the signs differ. HI = remainder, negated if the dividend is negative.
  - `start` is ignored in FIX, because the issuing instruction is still in EX.
- **busy** = (IDLE & `start` & ~`flush`) | CALC. It is low in FIX, so the instruction advances while the commit happens.
- **Divide by zero:** runs the full latency, no exception. Raw LO = `0xFFFFFFFF`, raw HI = |a|, then sign fix applies.
  - Unsigned 5/0 → LO = `FFFFFFFF`, HI = `00000005`.
  - Signed −5/0 → LO = `00000001`, HI = `FFFFFFFB`.
- **flush:** in any state, next state is IDLE; HI/LO are not written and `done` stays 0. A flush during FIX suppresses the commit.
- **MTHI/MTLO:** `hi_write`/`lo_write` update the register at the clock edge in any state. The FIX commit has priority on the same edge, and the MT write is dropped.

## Timing
- **Reset** (resetn low, asynchronous): state = IDLE, counter = 0, hi = lo = 0, done = 0, busy = 0 (forced while in reset).
- **Start accepted in cycle T:**
  - busy is high in cycles T..T+32.
  - FIX occupies cycle T+33, with done = 1.
  - HI/LO are valid from cycle T+34.
- **Back-to-back:** the next mul/div can be in EX at T+34 and is accepted that cycle; there are no bubbles beyond its own latency.
- **Outputs:** `hi`/`lo`/`done` are registered or state-decoded. `busy` is combinational from `start`/`flush` in IDLE only.

## Configuration
- **`MULDIV_FAST_MUL_EN` defined:** MUL bypasses CALC. IDLE → FIX, and FIX computes the 32×32 product of the latched magnitudes with a single multiplier.
  - busy is high only in cycle T.
  - done is high and HI/LO are written in T+1.
  - DIV is unchanged.
- **Undefined:** MUL uses the 32-cycle iterative path described above.

## Test plan
- Unsigned MUL `FFFFFFFF`×`FFFFFFFF` → HI = `FFFFFFFE`, LO = `00000001`. busy is 33 cycles, or 1 cycle with `MULDIV_FAST_MUL_EN`; done is a single pulse.
- Signed DIV −7/2 (`FFFFFFF9`, `00000002`) → LO = `FFFFFFFD`, HI = `FFFFFFFF`, done at T+33. Also check signed `80000000`/`FFFFFFFF` → LO = `80000000`, HI = 0.
- Unsigned DIV 5/0 → LO = `FFFFFFFF`, HI = `00000005`. Signed −5/0 → LO = `00000001`, HI = `FFFFFFFB`. No stall beyond 33 cycles.
- DIV started with HI = `AAAA0000`, flush at T+10 → IDLE at T+11, no done, HI unchanged. Repeat with the flush in the FIX cycle: HI unchanged.
- Signed MUL −3×4 immediately followed by MTHI `00001234` → after FIX, HI = `FFFFFFFF`, LO = `FFFFFFF4`. The next cycle, HI = `00001234` and LO is unchanged.
- resetn deasserted-to-low mid-CALC → asynchronous return to IDLE, hi = lo = 0, busy = 0. After release, a new MUL 6×7 gives LO = `0000002A`.
